// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command engine: command encodings,
// controller states and the mode-register word layout.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_NOP   = 3'b111
    } cmd_t;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_MRS,
        ST_IDLE,
        ST_ACT,
        ST_RW,
        ST_RD_WAIT,
        ST_RECOVER,
        ST_REF
    } state_t;

    // A10 selects all-bank precharge / auto-precharge on the access commands.
    localparam int AP_BIT     = 10;
    localparam int MRS_CL_LSB = 4;

    // Mode word: burst length 1, sequential, standard op mode, burst write
    // (A9=0); only the CAS latency field A[6:4] is non-zero.
    function automatic logic [15:0] mrs_word(input int cas_lat);
        logic [15:0] w;
        w = '0;
        w[MRS_CL_LSB +: 3] = 3'(cas_lat);
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer; raises pending every REF_INT cycles
// until the engine clears it by issuing a refresh.
module sdram_refresh_timer #(
    parameter int REF_INT = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic pending
);

    localparam int CW = $clog2(REF_INT + 1);

    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= CW'(REF_INT);
            pending <= 1'b0;
        end else begin
            cnt <= expire ? CW'(REF_INT) : cnt - 1'b1;
            // A fresh expiry wins over a clear landing in the same cycle.
            if (expire)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_cmd_engine.sv
// Single-access SDRAM command engine: power-up init, one ACT/RW with
// auto-precharge per request, periodic refresh. Optional SDRAM_REF_STATS_EN adds ref_count.
module sdram_cmd_engine
    import sdram_pkg::*;
#(
    parameter int ROW_W     = 13,
    parameter int COL_W     = 9,
    parameter int BA_W      = 2,
    parameter int DQ_W      = 16,
    parameter int CAS_LAT   = 2,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int T_WR      = 2,
    parameter int T_RFC     = 7,
    parameter int T_MRD     = 2,
    parameter int REF_INT   = 780,
    parameter int INIT_WAIT = 10000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [BA_W+ROW_W+COL_W-1:0] req_addr,
    input  logic [DQ_W-1:0]             req_wdata,
    output logic                        rsp_valid,
    output logic [DQ_W-1:0]             rsp_rdata,
    output logic [ROW_W-1:0]            sdram_addr,
    output logic [BA_W-1:0]             sdram_ba,
    output logic [DQ_W-1:0]             sdram_dq_o,
    output logic                        sdram_dq_oe,
    input  logic [DQ_W-1:0]             sdram_dq_i,
    output logic                        sdram_cke,
    output logic                        sdram_cs_n,
    output logic                        sdram_ras_n,
    output logic                        sdram_cas_n,
    output logic                        sdram_we_n,
    output logic [DQ_W/8-1:0]           sdram_dqm
`ifdef SDRAM_REF_STATS_EN
    ,
    output logic [15:0]                 ref_count
`endif
);

    localparam int CNT_MAX = max2(max2(INIT_WAIT - 1, T_RFC),
                                  max2(T_WR + T_RP, max2(T_MRD, CAS_LAT)));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [15:0] MRS_WORD = mrs_word(CAS_LAT);

    state_t             state;
    cmd_t               cmd;
    logic [CNT_W-1:0]   cnt;
    logic               done;
    logic               ref_pending;
    logic               ref_clear;
    logic               we_q;
    logic [COL_W-1:0]   col_q;
    logic [DQ_W-1:0]    wdata_q;
    logic [ROW_W-1:0]   acc_addr;
    logic [ROW_W-1:0]   pre_addr;

    assign done        = (cnt == '0);
    assign req_ready   = (state == ST_IDLE) && !ref_pending;
    assign ref_clear   = (state == ST_IDLE) && ref_pending;
    assign sdram_ras_n = cmd[2];
    assign sdram_cas_n = cmd[1];
    assign sdram_we_n  = cmd[0];

    always_comb begin
        acc_addr = '0;
        acc_addr[COL_W-1:0] = col_q;
        acc_addr[AP_BIT] = 1'b1;
        pre_addr = '0;
        pre_addr[AP_BIT] = 1'b1;
    end

    sdram_refresh_timer #(.REF_INT(REF_INT)) u_refresh_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (ref_clear),
        .pending (ref_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT_WAIT;
            cnt         <= CNT_W'(INIT_WAIT - 1);
            cmd         <= CMD_NOP;
            sdram_cke   <= 1'b0;
            sdram_cs_n  <= 1'b1;
            sdram_dqm   <= '1;
            sdram_addr  <= '0;
            sdram_ba    <= '0;
            sdram_dq_o  <= '0;
            sdram_dq_oe <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            we_q        <= 1'b0;
            col_q       <= '0;
            wdata_q     <= '0;
`ifdef SDRAM_REF_STATS_EN
            ref_count   <= '0;
`endif
        end else begin
            cmd         <= CMD_NOP;
            sdram_cke   <= 1'b1;
            sdram_dq_oe <= 1'b0;
            rsp_valid   <= 1'b0;
            if (!done)
                cnt <= cnt - 1'b1;

            case (state)
                ST_INIT_WAIT: if (done) begin
                    cmd        <= CMD_PRE;
                    sdram_addr <= pre_addr;
                    sdram_cs_n <= 1'b0;
                    sdram_dqm  <= '0;
                    cnt        <= CNT_W'(T_RP);
                    state      <= ST_INIT_PRE;
                end
                ST_INIT_PRE, ST_INIT_REF1: if (done) begin
                    cmd   <= CMD_REF;
                    cnt   <= CNT_W'(T_RFC);
                    state <= (state == ST_INIT_PRE) ? ST_INIT_REF1 : ST_INIT_REF2;
`ifdef SDRAM_REF_STATS_EN
                    ref_count <= ref_count + 16'd1;
`endif
                end
                ST_INIT_REF2: if (done) begin
                    cmd        <= CMD_MRS;
                    sdram_addr <= MRS_WORD[ROW_W-1:0];
                    cnt        <= CNT_W'(T_MRD);
                    state      <= ST_INIT_MRS;
                end
                ST_INIT_MRS: if (done) state <= ST_IDLE;
                ST_IDLE: begin
                    if (ref_pending) begin
                        cmd   <= CMD_REF;
                        cnt   <= CNT_W'(T_RFC);
                        state <= ST_REF;
`ifdef SDRAM_REF_STATS_EN
                        ref_count <= ref_count + 16'd1;
`endif
                    end else if (req_valid) begin
                        cmd        <= CMD_ACT;
                        sdram_ba   <= req_addr[COL_W+ROW_W +: BA_W];
                        sdram_addr <= req_addr[COL_W +: ROW_W];
                        we_q       <= req_we;
                        col_q      <= req_addr[COL_W-1:0];
                        wdata_q    <= req_wdata;
                        cnt        <= CNT_W'(T_RCD - 1);
                        state      <= ST_ACT;
                    end
                end
                ST_ACT: if (done) begin
                    cmd        <= we_q ? CMD_WRITE : CMD_READ;
                    sdram_addr <= acc_addr;
                    if (we_q) begin
                        sdram_dq_oe <= 1'b1;
                        sdram_dq_o  <= wdata_q;
                    end
                    state <= ST_RW;
                end
                // RW occupies the command cycle itself, hence the minus-one/two loads.
                ST_RW: begin
                    if (we_q) begin
                        cnt   <= CNT_W'(T_WR + T_RP - 2);
                        state <= ST_RECOVER;
                    end else begin
                        cnt   <= CNT_W'(CAS_LAT - 1);
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: if (done) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= sdram_dq_i;
                    cnt       <= CNT_W'(T_RP - 1);
                    state     <= ST_RECOVER;
                end
                ST_RECOVER, ST_REF: if (done) state <= ST_IDLE;
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end

endmodule

// File: doc/sdram_cmd_engine.md
SDRAM_CMD_ENGINE -- requirements
Module: sdram_cmd_engine

Interface
REQ-001 Parameters SHALL be:
- ROW_W 13: row address bits.
- COL_W 9: column address bits.
- BA_W 2: bank bits.
- DQ_W 16: data width.
- CAS_LAT 2: CAS latency, 2 or 3.
- T_RCD 2, T_RP 2, T_WR 2, T_RFC 7, T_MRD 2: SDRAM timings in cycles.
- REF_INT 780: cycles between refreshes.
- INIT_WAIT 10000: power-up wait in cycles.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk in 1: the single clock.
- rst in 1: reset, synchronous, active-high.
- req_valid in 1: request valid.
- req_ready out 1: request accepted when valid and ready are both high.
- req_we in 1: 1 = write, 0 = read.
- req_addr in BA_W+ROW_W+COL_W: {bank,row,col}.
- req_wdata in DQ_W: write data.
- rsp_valid out 1: read data valid, one-cycle pulse.
- rsp_rdata out DQ_W: read data.
- sdram_addr out ROW_W: address bus.
- sdram_ba out BA_W: bank select.
- sdram_dq_o out DQ_W: data to device.
- sdram_dq_oe out 1: data output enable.
- sdram_dq_i in DQ_W: data from device.
- sdram_cke out 1: clock enable.
- sdram_cs_n out 1: chip select.
- sdram_ras_n, sdram_cas_n, sdram_we_n out 1 each: command lines.
- sdram_dqm out DQ_W/8: byte masks.

Function
REQ-003 Every SDRAM output SHALL be registered. Commands are {ras_n,cas_n,we_n}: NOP 111, READ 101, WRITE 100, ACT 011, PRE 010, REF 001, MRS 000.
REQ-004 States SHALL be INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, ACT, RW, RD_WAIT, RECOVER, REF. One shared wait counter times each state; NOP is issued on every cycle not listed in REQ-005 to REQ-010.
REQ-005 Init sequence:
- INIT_WAIT: NOP for INIT_WAIT cycles, cke=1.
- INIT_PRE: PRE with addr[10]=1, then wait T_RP.
- INIT_REF1 and INIT_REF2: REF each, each followed by a T_RFC wait.
- INIT_MRS: MRS with addr = {0..., A9=0, A[8:7]=00, A[6:4]=CAS_LAT, A3=0, A[2:0]=000}, then wait T_MRD.
- Then go to IDLE.
REQ-006 req_ready SHALL be 1 only in IDLE with no refresh pending. It is combinational from state and the pending flag.
REQ-007 On acceptance, the ACT command (bank, row) SHALL appear on the bus in the next cycle. The access command follows T_RCD cycles after ACT with addr[10]=1 (auto-precharge) and column in the low COL_W bits.
REQ-008 Write: sdram_dq_oe=1 and sdram_dq_o=req_wdata (latched at accept) SHALL be driven only in the WRITE cycle. The engine then waits T_WR+T_RP cycles in RECOVER before IDLE.
REQ-009 Read: sdram_dq_i SHALL be sampled CAS_LAT cycles after the READ cycle. rsp_valid pulses, with the sampled data, one cycle later. The engine then waits T_RP in RECOVER.
REQ-010 Refresh:
- A down-counter reloads REF_INT and sets ref_pending on reaching 0. The count continues during accesses.
- In IDLE, ref_pending beats req_valid when both are present in the same cycle.
- REF is issued, ref_pending is cleared, and the engine waits T_RFC.
- If expiry coincides with REF issue, ref_pending stays set.
REQ-011 sdram_cs_n=0 and sdram_dqm=0 SHALL hold after INIT_WAIT.
REQ-012 Counter widths SHALL be $clog2 of the largest value they hold. A request arriving during init SHALL be held off via req_ready=0 and never dropped.

Reset
REQ-013 rst at any time, including mid-access, SHALL force INIT_WAIT and restart the full init sequence.
REQ-014 Reset values SHALL be: req_ready=0, rsp_valid=0, rsp_rdata=0, cke=0, cs_n=1, ras_n/cas_n/we_n=111, addr=0, ba=0, dq_oe=0, dq_o=0, dqm all ones, ref_pending=0, refresh counter=REF_INT.

Configuration
REQ-015 SDRAM_REF_STATS_EN defined SHALL add output ref_count (16 bits). It is reset to 0, increments on each REF issued (init included), and wraps at 0xFFFF->0. Without the macro the port and its logic SHALL be absent.

Structure
REQ-016 Command encodings, the state enum and the MRS field layout SHALL live in shared package sdram_pkg.
REQ-017 The refresh timer SHALL be sub-module sdram_refresh_timer (clk, rst, clear, pending).

Verification
REQ-018 The bench SHALL use INIT_WAIT=20 and other defaults, and cover:
- Reset release: PRE at cycle 20, REF at 23 and 31, MRS at 39 with addr=0x020, req_ready=1 at 42.
- Write 0xA5A5 to bank 1, row 0x0123, col 0x045: ACT ba=1 addr=0x0123 one cycle after accept; WRITE 2 cycles later with addr=0x445, dq_oe=1, dq_o=0xA5A5; req_ready back after 4 more cycles.
- Read with sdram_dq_i=0x3C3C at READ+2: rsp_valid pulses at READ+3 with rsp_rdata=0x3C3C.
- ref_pending and req_valid in the same IDLE cycle: REF issued first, ACT issued after the T_RFC wait.
- rst asserted in RW state: next cycle all outputs at reset values, init restarts.
- With SDRAM_REF_STATS_EN: ref_count=2 after init and 3 after the first periodic refresh.
